// File: rtl/tcm_port_arbiter.sv
// -----------------------------------------------------------------------------
// tcm_port_arbiter
//
// Purpose:
//   Sits directly upstream of one port of the dual-port TCM BRAM. Two masters
//   share the port: m0 is the instruction fetch (read-only) and m1 is the
//   load/store unit (read/write). Each master's request is captured into its
//   own pending slot. A four-state FSM (IDLE, ISSUE, WAIT, RESP) grants one
//   slot at a time, drives a single-cycle BRAM access, captures the registered
//   read data and returns a one-cycle ready pulse to the winner. An address
//   outside the TCM window gets an immediate error response and the BRAM is
//   never touched.
//
//   In-range access: strobe in T, sram_en_o in T+2, ready_o in T+4.
//   Out-of-range access: strobe in T, ready_o in T+2.
//   Back-to-back grants from RESP give one access every 3 cycles.
//
// Build option:
//   TCM_ROUND_ROBIN_EN - when defined, a grant with both slots pending goes
//                        to the master that did not win the previous grant.
//                        When undefined, m1 has fixed priority over m0.
//
// Ports:
//   clk_i, rst_i         clock; synchronous active-high reset
//   m0_strobe_i          fetch request pulse
//   m0_addr_i            fetch byte address
//   m0_data_o            fetch read data (held until the next m0 response)
//   m0_ready_o           fetch response pulse
//   m0_error_o           fetch out-of-range flag, valid with m0_ready_o
//   m1_strobe_i          data request pulse
//   m1_rw_i              1 = write, 0 = read
//   m1_byte_enable_i     write byte enables
//   m1_addr_i            data byte address
//   m1_data_i            write data
//   m1_data_o            read data (0 for writes, held until next m1 response)
//   m1_ready_o           data response pulse
//   m1_error_o           data out-of-range flag, valid with m1_ready_o
//   sram_en_o            BRAM port enable (high only in ISSUE)
//   sram_we_o            BRAM write enable
//   sram_be_o            BRAM byte enables (0 for reads)
//   sram_addr_o          BRAM word address
//   sram_data_o          BRAM write data
//   sram_data_i          BRAM registered read data
//   sram_ready_i         BRAM ready, high the cycle after sram_en_o
// -----------------------------------------------------------------------------
module tcm_port_arbiter #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    N_ENTRIES  = 1024,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] TCM_BASE   = 32'h0000_0000
) (
    input  logic                         clk_i,
    input  logic                         rst_i,

    input  logic                         m0_strobe_i,
    input  logic [ADDR_WIDTH-1:0]        m0_addr_i,
    output logic [DATA_WIDTH-1:0]        m0_data_o,
    output logic                         m0_ready_o,
    output logic                         m0_error_o,

    input  logic                         m1_strobe_i,
    input  logic                         m1_rw_i,
    input  logic [DATA_WIDTH/8-1:0]      m1_byte_enable_i,
    input  logic [ADDR_WIDTH-1:0]        m1_addr_i,
    input  logic [DATA_WIDTH-1:0]        m1_data_i,
    output logic [DATA_WIDTH-1:0]        m1_data_o,
    output logic                         m1_ready_o,
    output logic                         m1_error_o,

    output logic                         sram_en_o,
    output logic                         sram_we_o,
    output logic [DATA_WIDTH/8-1:0]      sram_be_o,
    output logic [$clog2(N_ENTRIES)-1:0] sram_addr_o,
    output logic [DATA_WIDTH-1:0]        sram_data_o,
    input  logic [DATA_WIDTH-1:0]        sram_data_i,
    input  logic                         sram_ready_i
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int IDX_W = $clog2(N_ENTRIES);
    localparam int OFS_W = $clog2(BE_W);

    // Window size in bytes, one bit wider than an address so it cannot wrap.
    localparam logic [ADDR_WIDTH:0] WINDOW_BYTES =
        (ADDR_WIDTH+1)'(N_ENTRIES) * (ADDR_WIDTH+1)'(BE_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Offset is taken modulo 2^ADDR_WIDTH, so addresses below the base wrap
    // to huge offsets and fall out of the window.
    function automatic logic in_window(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] ofs;
        ofs = addr - TCM_BASE;
        return {1'b0, ofs} < WINDOW_BYTES;
    endfunction

    // Byte-offset bits inside a word are dropped.
    function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] ofs;
        ofs = addr - TCM_BASE;
        return IDX_W'(ofs >> OFS_W);
    endfunction

    state_t                  state_q;
    logic                    pend0_q, pend1_q;
    logic                    grant_m1_q, grant_rw_q;

    logic [ADDR_WIDTH-1:0]   slot0_addr_q;
    logic [ADDR_WIDTH-1:0]   slot1_addr_q;
    logic                    slot1_rw_q;
    logic [BE_W-1:0]         slot1_be_q;
    logic [DATA_WIDTH-1:0]   slot1_wdata_q;

    logic                    m0_ready_q, m0_error_q, m1_ready_q, m1_error_q;
    logic [DATA_WIDTH-1:0]   m0_data_q, m1_data_q;
    logic                    sram_en_q, sram_we_q;
    logic [BE_W-1:0]         sram_be_q;
    logic [IDX_W-1:0]        sram_addr_q;
    logic [DATA_WIDTH-1:0]   sram_data_q;

`ifdef TCM_ROUND_ROBIN_EN
    logic                    last_m1_q;
`endif

    // Grant decision for the current cycle.
    logic                    gnt_take, gnt_m1, gnt_rw, gnt_inr;
    logic [ADDR_WIDTH-1:0]   gnt_addr;
    logic [BE_W-1:0]         gnt_be;
    logic [DATA_WIDTH-1:0]   gnt_wdata;

    always_comb begin
        gnt_m1 = pend1_q;
`ifdef TCM_ROUND_ROBIN_EN
        if (pend0_q && pend1_q) begin
            gnt_m1 = ~last_m1_q;
        end
`endif
        gnt_addr  = gnt_m1 ? slot1_addr_q : slot0_addr_q;
        gnt_rw    = gnt_m1 & slot1_rw_q;
        gnt_be    = gnt_m1 ? slot1_be_q : '0;
        gnt_wdata = gnt_m1 ? slot1_wdata_q : '0;
        gnt_take  = (pend0_q | pend1_q) && (state_q == ST_IDLE || state_q == ST_RESP);
        gnt_inr   = in_window(gnt_addr);
    end

    // Request payload capture; the pending flags themselves live in the FSM
    // block. A strobe is taken only when the slot is free, so an ignored
    // strobe leaves the first request intact.
    always_ff @(posedge clk_i) begin
        if (!pend0_q && m0_strobe_i) begin
            slot0_addr_q <= m0_addr_i;
        end
        if (!pend1_q && m1_strobe_i) begin
            slot1_addr_q  <= m1_addr_i;
            slot1_rw_q    <= m1_rw_i;
            slot1_be_q    <= m1_byte_enable_i;
            slot1_wdata_q <= m1_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            pend0_q     <= 1'b0;
            pend1_q     <= 1'b0;
            grant_m1_q  <= 1'b0;
            grant_rw_q  <= 1'b0;
            m0_ready_q  <= 1'b0;
            m0_error_q  <= 1'b0;
            m0_data_q   <= '0;
            m1_ready_q  <= 1'b0;
            m1_error_q  <= 1'b0;
            m1_data_q   <= '0;
            sram_en_q   <= 1'b0;
            sram_we_q   <= 1'b0;
            sram_be_q   <= '0;
            sram_addr_q <= '0;
            sram_data_q <= '0;
`ifdef TCM_ROUND_ROBIN_EN
            last_m1_q   <= 1'b1;
`endif
        end else begin
            // Response and BRAM strobes are single-cycle pulses.
            m0_ready_q  <= 1'b0;
            m0_error_q  <= 1'b0;
            m1_ready_q  <= 1'b0;
            m1_error_q  <= 1'b0;
            sram_en_q   <= 1'b0;
            sram_we_q   <= 1'b0;
            sram_be_q   <= '0;
            sram_addr_q <= '0;
            sram_data_q <= '0;

            if (!pend0_q) begin
                pend0_q <= m0_strobe_i;
            end else if (gnt_take && !gnt_m1) begin
                pend0_q <= 1'b0;
            end
            if (!pend1_q) begin
                pend1_q <= m1_strobe_i;
            end else if (gnt_take && gnt_m1) begin
                pend1_q <= 1'b0;
            end

            case (state_q)
                // RESP grants exactly like IDLE so accesses can run back to back.
                ST_IDLE, ST_RESP: begin
                    if (gnt_take) begin
                        grant_m1_q <= gnt_m1;
                        grant_rw_q <= gnt_rw;
`ifdef TCM_ROUND_ROBIN_EN
                        last_m1_q  <= gnt_m1;
`endif
                        if (gnt_inr) begin
                            state_q     <= ST_ISSUE;
                            sram_en_q   <= 1'b1;
                            sram_we_q   <= gnt_rw;
                            sram_be_q   <= gnt_rw ? gnt_be : '0;
                            sram_addr_q <= word_index(gnt_addr);
                            sram_data_q <= gnt_wdata;
                        end else begin
                            state_q <= ST_RESP;
                            if (gnt_m1) begin
                                m1_ready_q <= 1'b1;
                                m1_error_q <= 1'b1;
                                m1_data_q  <= '0;
                            end else begin
                                m0_ready_q <= 1'b1;
                                m0_error_q <= 1'b1;
                                m0_data_q  <= '0;
                            end
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end

                ST_ISSUE: begin
                    state_q <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (sram_ready_i) begin
                        state_q <= ST_RESP;
                        if (grant_m1_q) begin
                            m1_ready_q <= 1'b1;
                            m1_data_q  <= grant_rw_q ? '0 : sram_data_i;
                        end else begin
                            m0_ready_q <= 1'b1;
                            m0_data_q  <= sram_data_i;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign m0_data_o   = m0_data_q;
    assign m0_ready_o  = m0_ready_q;
    assign m0_error_o  = m0_error_q;
    assign m1_data_o   = m1_data_q;
    assign m1_ready_o  = m1_ready_q;
    assign m1_error_o  = m1_error_q;
    assign sram_en_o   = sram_en_q;
    assign sram_we_o   = sram_we_q;
    assign sram_be_o   = sram_be_q;
    assign sram_addr_o = sram_addr_q;
    assign sram_data_o = sram_data_q;

endmodule

// File: tb/tb_tcm_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tcm_port_arbiter
//
// Bench for tcm_port_arbiter with default parameters. Contains a simple BRAM
// (registered read, ready one cycle after enable), a timeline reference model
// that schedules the expected BRAM strobes and responses from the latency and
// arbitration rules, a per-cycle compare process, and directed stimulus with
// hand-computed literal expectations. Honours TCM_ROUND_ROBIN_EN the same way
// the design does.
// -----------------------------------------------------------------------------
module tb_tcm_port_arbiter;

    localparam int MAXC = 2048;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        m0_strobe_i;
    logic [31:0] m0_addr_i;
    logic [31:0] m0_data_o;
    logic        m0_ready_o, m0_error_o;
    logic        m1_strobe_i, m1_rw_i;
    logic [3:0]  m1_byte_enable_i;
    logic [31:0] m1_addr_i, m1_data_i;
    logic [31:0] m1_data_o;
    logic        m1_ready_o, m1_error_o;
    logic        sram_en_o, sram_we_o;
    logic [3:0]  sram_be_o;
    logic [9:0]  sram_addr_o;
    logic [31:0] sram_data_o;
    logic [31:0] sram_data_i = '0;
    logic        sram_ready_i = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    tcm_port_arbiter dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .m0_strobe_i      (m0_strobe_i),
        .m0_addr_i        (m0_addr_i),
        .m0_data_o        (m0_data_o),
        .m0_ready_o       (m0_ready_o),
        .m0_error_o       (m0_error_o),
        .m1_strobe_i      (m1_strobe_i),
        .m1_rw_i          (m1_rw_i),
        .m1_byte_enable_i (m1_byte_enable_i),
        .m1_addr_i        (m1_addr_i),
        .m1_data_i        (m1_data_i),
        .m1_data_o        (m1_data_o),
        .m1_ready_o       (m1_ready_o),
        .m1_error_o       (m1_error_o),
        .sram_en_o        (sram_en_o),
        .sram_we_o        (sram_we_o),
        .sram_be_o        (sram_be_o),
        .sram_addr_o      (sram_addr_o),
        .sram_data_o      (sram_data_o),
        .sram_data_i      (sram_data_i),
        .sram_ready_i     (sram_ready_i)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- BRAM ----------------
    logic [31:0] bram_mem [1024];
    logic [31:0] ref_mem  [1024];

    initial begin
        for (int k = 0; k < 1024; k++) begin
            bram_mem[k] = 32'h1000_0000 + k;
            ref_mem[k]  = 32'h1000_0000 + k;
        end
        bram_mem[4] = 32'hDEAD_BEEF; ref_mem[4] = 32'hDEAD_BEEF;
        bram_mem[8] = 32'hAAAA_AAAA; ref_mem[8] = 32'hAAAA_AAAA;
    end

    always @(posedge clk) begin
        sram_ready_i <= sram_en_o;
        if (sram_en_o) begin
            if (sram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be_o[b]) bram_mem[sram_addr_o][8*b +: 8] <= sram_data_o[8*b +: 8];
            end else begin
                sram_data_i <= bram_mem[sram_addr_o];
            end
        end
    end

    // ---------------- reference model: timeline of expected events ----------------
    bit        exp_en [MAXC];
    bit        exp_we [MAXC];
    bit [3:0]  exp_be [MAXC];
    bit [9:0]  exp_ad [MAXC];
    bit [31:0] exp_wd [MAXC];
    bit        exp_r0 [MAXC];
    bit        exp_r1 [MAXC];
    bit        exp_e0 [MAXC];
    bit        exp_e1 [MAXC];
    bit [31:0] exp_d0 [MAXC];
    bit [31:0] exp_d1 [MAXC];
    bit        exp_clr[MAXC];

    bit        pend0, pend1, p1_rw;
    bit [31:0] p0_addr, p1_addr, p1_wd;
    bit [3:0]  p1_be;
    int        next_free = 0;
`ifdef TCM_ROUND_ROBIN_EN
    bit        last1 = 1'b1;
`endif

    always @(posedge clk) begin
        int c;
        bit old0, old1, win1, rw, inr;
        bit [31:0] addr, wd, ofs, d;
        bit [3:0] be;
        int idx;
        c = cyc;
        if (rst_i) begin
            pend0 = 0; pend1 = 0; next_free = c + 1;
`ifdef TCM_ROUND_ROBIN_EN
            last1 = 1'b1;
`endif
            for (int k = c + 1; k <= c + 4 && k < MAXC; k++) begin
                exp_en[k] = 0; exp_we[k] = 0; exp_be[k] = 0; exp_ad[k] = 0; exp_wd[k] = 0;
                exp_r0[k] = 0; exp_r1[k] = 0; exp_e0[k] = 0; exp_e1[k] = 0;
                exp_d0[k] = 0; exp_d1[k] = 0;
            end
            if (c + 1 < MAXC) exp_clr[c+1] = 1;
        end else begin
            old0 = pend0; old1 = pend1;
            if (c >= next_free && (pend0 || pend1) && c + 3 < MAXC) begin
                win1 = pend1;
`ifdef TCM_ROUND_ROBIN_EN
                if (pend0 && pend1) win1 = !last1;
                last1 = win1;
`endif
                if (win1) begin
                    addr = p1_addr; rw = p1_rw; be = p1_be; wd = p1_wd; pend1 = 0;
                end else begin
                    addr = p0_addr; rw = 0; be = 0; wd = 0; pend0 = 0;
                end
                ofs = addr - 32'h0;
                inr = ofs < 32'd4096;
                if (inr) begin
                    idx = int'(ofs >> 2);
                    exp_en[c+1] = 1; exp_we[c+1] = rw; exp_be[c+1] = rw ? be : 4'b0;
                    exp_ad[c+1] = idx[9:0]; exp_wd[c+1] = wd;
                    if (rw) begin
                        for (int b = 0; b < 4; b++)
                            if (be[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
                        d = 0;
                    end else begin
                        d = ref_mem[idx];
                    end
                    if (win1) begin exp_r1[c+3] = 1; exp_e1[c+3] = 0; exp_d1[c+3] = d; end
                    else      begin exp_r0[c+3] = 1; exp_e0[c+3] = 0; exp_d0[c+3] = d; end
                    next_free = c + 3;
                end else begin
                    if (win1) begin exp_r1[c+1] = 1; exp_e1[c+1] = 1; exp_d1[c+1] = 0; end
                    else      begin exp_r0[c+1] = 1; exp_e0[c+1] = 1; exp_d0[c+1] = 0; end
                    next_free = c + 1;
                end
            end
            if (!old0 && m0_strobe_i) begin pend0 = 1; p0_addr = m0_addr_i; end
            if (!old1 && m1_strobe_i) begin
                pend1 = 1; p1_addr = m1_addr_i; p1_rw = m1_rw_i;
                p1_be = m1_byte_enable_i; p1_wd = m1_data_i;
            end
        end
        cyc = cyc + 1;
    end

    // ---------------- per-cycle compare ----------------
    bit [31:0] cur0 = 0, cur1 = 0;

    always @(negedge clk) begin
        int k;
        k = cyc;
        if (k > 0 && k < MAXC) begin
            if (exp_clr[k]) begin cur0 = 0; cur1 = 0; end
            if (exp_r0[k]) cur0 = exp_d0[k];
            if (exp_r1[k]) cur1 = exp_d1[k];
            check($sformatf("c%0d sram_en", k),   sram_en_o,   exp_en[k]);
            check($sformatf("c%0d sram_we", k),   sram_we_o,   exp_we[k]);
            check($sformatf("c%0d sram_be", k),   sram_be_o,   exp_be[k]);
            check($sformatf("c%0d sram_addr", k), sram_addr_o, exp_ad[k]);
            check($sformatf("c%0d sram_data", k), sram_data_o, exp_wd[k]);
            check($sformatf("c%0d m0_ready", k),  m0_ready_o,  exp_r0[k]);
            check($sformatf("c%0d m1_ready", k),  m1_ready_o,  exp_r1[k]);
            check($sformatf("c%0d m0_data", k),   m0_data_o,   cur0);
            check($sformatf("c%0d m1_data", k),   m1_data_o,   cur1);
            if (exp_r0[k]) check($sformatf("c%0d m0_error", k), m0_error_o, exp_e0[k]);
            if (exp_r1[k]) check($sformatf("c%0d m1_error", k), m1_error_o, exp_e1[k]);
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic idle_inputs();
        m0_strobe_i = 0; m0_addr_i = 0;
        m1_strobe_i = 0; m1_rw_i = 0; m1_byte_enable_i = 0; m1_addr_i = 0; m1_data_i = 0;
    endtask

    task automatic set_m1(input bit rw, input bit [3:0] be, input bit [31:0] a, input bit [31:0] d);
        m1_strobe_i = 1; m1_rw_i = rw; m1_byte_enable_i = be; m1_addr_i = a; m1_data_i = d;
    endtask

    initial begin
        int t;
        rst_i = 1;
        idle_inputs();
        repeat (3) @(negedge clk);
        check("reset m0_ready", m0_ready_o, 0);
        check("reset m1_ready", m1_ready_o, 0);
        check("reset sram_en", sram_en_o, 0);
        check("reset m0_data", m0_data_o, 0);
        rst_i = 0;
        @(negedge clk);

        // m0 read of 0x10 -> word 4
        t = cyc; m0_strobe_i = 1; m0_addr_i = 32'h10;
        @(negedge clk); idle_inputs();
        wait_to(t + 2);
        check("rd0 sram_en", sram_en_o, 1);
        check("rd0 sram_addr", sram_addr_o, 4);
        check("rd0 sram_we", sram_we_o, 0);
        wait_to(t + 4);
        check("rd0 m0_ready", m0_ready_o, 1);
        check("rd0 m0_data", m0_data_o, 32'hDEAD_BEEF);
        check("rd0 m0_error", m0_error_o, 0);
        wait_to(t + 6);

        // m1 partial write, then a read strobed in the same cycle as the write's ready
        t = cyc; set_m1(1, 4'b0011, 32'h20, 32'h1234_5678);
        @(negedge clk); idle_inputs();
        wait_to(t + 2);
        check("wr sram_we", sram_we_o, 1);
        check("wr sram_be", sram_be_o, 4'b0011);
        check("wr sram_addr", sram_addr_o, 8);
        check("wr sram_data", sram_data_o, 32'h1234_5678);
        wait_to(t + 4);
        check("wr m1_ready", m1_ready_o, 1);
        check("wr m1_data", m1_data_o, 0);
        set_m1(0, 4'b0000, 32'h20, 32'h0);
        t = cyc;
        @(negedge clk); idle_inputs();
        wait_to(t + 2);
        check("rdback sram_be", sram_be_o, 0);
        wait_to(t + 4);
        check("rdback m1_ready", m1_ready_o, 1);
        check("rdback m1_data", m1_data_o, 32'hAAAA_5678);
        wait_to(t + 6);

        // m1 out-of-range read: just past the window
        t = cyc; set_m1(0, 4'b0000, 32'h1000, 32'h0);
        @(negedge clk); idle_inputs();
        check("oor sram_en t+1", sram_en_o, 0);
        wait_to(t + 2);
        check("oor m1_ready", m1_ready_o, 1);
        check("oor m1_error", m1_error_o, 1);
        check("oor m1_data", m1_data_o, 0);
        check("oor sram_en t+2", sram_en_o, 0);
        wait_to(t + 4);

        // m0 read of the last byte of the window, unaligned -> word 1023
        t = cyc; m0_strobe_i = 1; m0_addr_i = 32'hFFF;
        @(negedge clk); idle_inputs();
        wait_to(t + 2);
        check("last sram_addr", sram_addr_o, 10'd1023);
        wait_to(t + 4);
        check("last m0_data", m0_data_o, 32'h1000_03FF);
        wait_to(t + 6);

        // m0 read below the base wraps to a huge offset -> error
        t = cyc; m0_strobe_i = 1; m0_addr_i = 32'hFFFF_FFFC;
        @(negedge clk); idle_inputs();
        wait_to(t + 2);
        check("wrap m0_ready", m0_ready_o, 1);
        check("wrap m0_error", m0_error_o, 1);
        wait_to(t + 4);

        // simultaneous strobes; last grant was m0, so both builds serve m1 first
        for (int i = 0; i < 4; i++) begin
            t = cyc;
            m0_strobe_i = 1; m0_addr_i = 32'h100 + 8*i;
            set_m1(0, 4'b0000, 32'h200 + 8*i, 32'h0);
            @(negedge clk); idle_inputs();
            wait_to(t + 4);
            check($sformatf("sim%0d first m1_ready", i), m1_ready_o, 1);
            check($sformatf("sim%0d first m1_data", i), m1_data_o, 32'h1000_0080 + 2*i);
            check($sformatf("sim%0d first m0_ready", i), m0_ready_o, 0);
            wait_to(t + 7);
            check($sformatf("sim%0d second m0_ready", i), m0_ready_o, 1);
            check($sformatf("sim%0d second m0_data", i), m0_data_o, 32'h1000_0040 + 2*i);
            wait_to(t + 8);
        end

        // strobe while pending is ignored; then both slots pending at a RESP grant
        t = cyc; set_m1(0, 4'b0000, 32'h30, 32'h0);
        @(negedge clk);
        set_m1(0, 4'b0000, 32'h40, 32'h0);
        m0_strobe_i = 1; m0_addr_i = 32'h50;
        @(negedge clk);
        m0_strobe_i = 0; m0_addr_i = 0;
        set_m1(0, 4'b0000, 32'h44, 32'h0);
        @(negedge clk); idle_inputs();
        wait_to(t + 4);
        check("ign m1_data", m1_data_o, 32'h1000_000C);
        wait_to(t + 7);
`ifdef TCM_ROUND_ROBIN_EN
        check("rr m0_ready", m0_ready_o, 1);
        check("rr m0_data", m0_data_o, 32'h1000_0014);
`else
        check("fp m1_ready", m1_ready_o, 1);
        check("fp m1_data", m1_data_o, 32'h1000_0011);
`endif
        wait_to(t + 12);

        // reset while in WAIT drops the access
        t = cyc; m0_strobe_i = 1; m0_addr_i = 32'h10;
        @(negedge clk); idle_inputs();
        wait_to(t + 3);
        rst_i = 1;
        wait_to(t + 4);
        check("rstw m0_ready", m0_ready_o, 0);
        check("rstw m0_data", m0_data_o, 0);
        check("rstw m1_data", m1_data_o, 0);
        check("rstw sram_en", sram_en_o, 0);
        rst_i = 0;
        wait_to(t + 6);
        t = cyc; set_m1(0, 4'b0000, 32'h20, 32'h0);
        @(negedge clk); idle_inputs();
        wait_to(t + 4);
        check("post m1_ready", m1_ready_o, 1);
        check("post m1_data", m1_data_o, 32'hAAAA_5678);
        wait_to(t + 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish within 20000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
